// File: rtl/z_altitude_sampler_pkg.sv
// Shared widths, state encoding and the range clamp for the altitude sampler.
package z_altitude_sampler_pkg;

  localparam int RATE_BIT_WIDTH       = 16;
  localparam int ZAS_CNT_WIDTH        = 16;
  localparam int ZAS_CALC_WIDTH       = 18;
  localparam int ZAS_NUM_STATES       = 5;
  localparam int ZAS_SAMPLE_PERIOD_US = 20000;

  typedef enum logic [ZAS_NUM_STATES-1:0] {
    ZAS_INIT      = 5'b00001,
    ZAS_WAIT_RISE = 5'b00010,
    ZAS_MEASURE   = 5'b00100,
    ZAS_COMPUTE   = 5'b01000,
    ZAS_ABORT     = 5'b10000
  } zas_state_t;

  // Clamp a signed intermediate range to [0, max_mm]; the wide input never wraps.
  function automatic logic signed [RATE_BIT_WIDTH-1:0] clamp_mm(
    input logic signed [ZAS_CALC_WIDTH-1:0] val,
    input logic signed [ZAS_CALC_WIDTH-1:0] max_mm
  );
    if (val[ZAS_CALC_WIDTH-1]) begin
      return '0;
    end else if (val > max_mm) begin
      return max_mm[RATE_BIT_WIDTH-1:0];
    end else begin
      return val[RATE_BIT_WIDTH-1:0];
    end
  endfunction

endpackage

// File: rtl/z_altitude_sampler_pwm_sync_edge.sv
// Two-flop synchronizer with registered rise/fall pulses for an asynchronous PWM pin.
module pwm_sync_edge (
  input  logic us_clk,
  input  logic resetn,
  input  logic pwm,
  output logic rise,
  output logic fall
);

  logic       meta_r;
  logic       sync_r;
  logic [1:0] arm_r;
  logic       rise_r;
  logic       fall_r;

  // Edges are suppressed until the chain is filled, so a pin already high at reset release is not a rise.
  always_ff @(posedge us_clk or negedge resetn) begin
    if (!resetn) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
      arm_r  <= 2'b00;
      rise_r <= 1'b0;
      fall_r <= 1'b0;
    end else begin
      meta_r <= pwm;
      sync_r <= meta_r;
      arm_r  <= {arm_r[0], 1'b1};
      rise_r <= arm_r[1] & meta_r & ~sync_r;
      fall_r <= arm_r[1] & ~meta_r & sync_r;
    end
  end

  assign rise = rise_r;
  assign fall = fall_r;

endmodule

// File: rtl/z_altitude_sampler.sv
// LIDAR-Lite PWM width to altitude, published on a fixed-rate tick with freshness and stale-fault flags.
module z_altitude_sampler
  import z_altitude_sampler_pkg::*;
#(
  parameter int SAMPLE_PERIOD_US = ZAS_SAMPLE_PERIOD_US,
  parameter int TIMEOUT_US       = 40000,
  parameter int MIN_PULSE_US     = 100,
  parameter int OFFSET_MM        = 0,
  parameter int MAX_MM           = 30000,
  parameter int STALE_LIMIT      = 5
) (
  input  logic                             us_clk,
  input  logic                             resetn,
  input  logic                             lidar_pwm,
  output logic signed [RATE_BIT_WIDTH-1:0] z_altitude_mm,
  output logic                             start_signal,
  output logic                             altitude_valid,
  output logic                             sensor_fault
);

  localparam int STALE_W = $clog2(STALE_LIMIT + 1);
  localparam logic [ZAS_CNT_WIDTH-1:0] TIMEOUT_LAST = ZAS_CNT_WIDTH'(TIMEOUT_US - 1);
  localparam logic [ZAS_CNT_WIDTH-1:0] PERIOD_LAST  = ZAS_CNT_WIDTH'(SAMPLE_PERIOD_US - 1);
  localparam logic [ZAS_CNT_WIDTH-1:0] MIN_PULSE    = ZAS_CNT_WIDTH'(MIN_PULSE_US);
  localparam logic signed [ZAS_CALC_WIDTH-1:0] OFFSET_C = ZAS_CALC_WIDTH'(OFFSET_MM);
  localparam logic signed [ZAS_CALC_WIDTH-1:0] MAX_C    = ZAS_CALC_WIDTH'(MAX_MM);
  localparam logic [STALE_W-1:0] STALE_MAX = STALE_W'(STALE_LIMIT);

  logic rise_s;
  logic fall_s;

  zas_state_t                       state_r,   state_nxt;
  logic [ZAS_CNT_WIDTH-1:0]         to_cnt_r,  to_cnt_nxt;
  logic [ZAS_CNT_WIDTH-1:0]         width_r,   width_nxt;
  logic [ZAS_CNT_WIDTH-1:0]         period_r,  period_nxt;
  logic signed [RATE_BIT_WIDTH-1:0] pending_r, pending_nxt;
  logic                             fresh_r,   fresh_nxt;
  logic signed [RATE_BIT_WIDTH-1:0] z_r,       z_nxt;
  logic                             start_r,   start_nxt;
  logic                             valid_r,   valid_nxt;
  logic [STALE_W-1:0]               stale_r,   stale_nxt;
  logic                             fault_r,   fault_nxt;
  logic                             accept_s;
  logic                             tick_s;
  logic signed [ZAS_CALC_WIDTH-1:0] calc_s;

  pwm_sync_edge u_sync (
    .us_clk (us_clk),
    .resetn (resetn),
    .pwm    (lidar_pwm),
    .rise   (rise_s),
    .fall   (fall_s)
  );

  // Measurement FSM next-state and counters.
  always_comb begin
    state_nxt  = state_r;
    to_cnt_nxt = to_cnt_r;
    width_nxt  = width_r;
    accept_s   = 1'b0;
    calc_s     = $signed({{(ZAS_CALC_WIDTH-ZAS_CNT_WIDTH){1'b0}}, width_r}) - OFFSET_C;
    case (state_r)
      ZAS_INIT: begin
        state_nxt  = ZAS_WAIT_RISE;
        to_cnt_nxt = '0;
        width_nxt  = '0;
      end
      ZAS_WAIT_RISE: begin
        width_nxt = '0;
        if (rise_s) begin
          state_nxt  = ZAS_MEASURE;
          to_cnt_nxt = '0;
        end else if (to_cnt_r == TIMEOUT_LAST) begin
          state_nxt  = ZAS_ABORT;
          to_cnt_nxt = '0;
        end else begin
          to_cnt_nxt = to_cnt_r + 1'b1;
        end
      end
      ZAS_MEASURE: begin
        // The fall is seen one cycle after the last high sample, so counting that cycle too yields the true width.
        width_nxt = width_r + 1'b1;
        if (fall_s) begin
          state_nxt = ZAS_COMPUTE;
        end else if (width_r == TIMEOUT_LAST) begin
          state_nxt = ZAS_ABORT;
        end else begin
          state_nxt = ZAS_MEASURE;
        end
      end
      ZAS_COMPUTE: begin
        state_nxt = ZAS_WAIT_RISE;
        accept_s  = (width_r >= MIN_PULSE);
      end
      ZAS_ABORT: begin
        state_nxt = ZAS_WAIT_RISE;
      end
      default: begin
        state_nxt = ZAS_INIT;
      end
    endcase
  end

  // Publish tick, pending result and stale tracking.
  always_comb begin
    tick_s      = (period_r == PERIOD_LAST);
    period_nxt  = tick_s ? '0 : period_r + 1'b1;
    start_nxt   = tick_s;
    pending_nxt = accept_s ? clamp_mm(calc_s, MAX_C) : pending_r;
    // A result landing on the tick edge survives for the next tick.
    fresh_nxt   = accept_s ? 1'b1 : (tick_s ? 1'b0 : fresh_r);
    z_nxt       = (tick_s && fresh_r) ? pending_r : z_r;
    valid_nxt   = tick_s ? fresh_r : valid_r;
    if (!tick_s) begin
      stale_nxt = stale_r;
    end else if (fresh_r) begin
      stale_nxt = '0;
    end else if (stale_r == STALE_MAX) begin
      stale_nxt = stale_r;
    end else begin
      stale_nxt = stale_r + 1'b1;
    end
    fault_nxt = (stale_nxt == STALE_MAX);
  end

  // State and output registers.
  always_ff @(posedge us_clk or negedge resetn) begin
    if (!resetn) begin
      state_r   <= ZAS_INIT;
      to_cnt_r  <= '0;
      width_r   <= '0;
      period_r  <= '0;
      pending_r <= '0;
      fresh_r   <= 1'b0;
      z_r       <= '0;
      start_r   <= 1'b0;
      valid_r   <= 1'b0;
      stale_r   <= '0;
      fault_r   <= 1'b0;
    end else begin
      state_r   <= state_nxt;
      to_cnt_r  <= to_cnt_nxt;
      width_r   <= width_nxt;
      period_r  <= period_nxt;
      pending_r <= pending_nxt;
      fresh_r   <= fresh_nxt;
      z_r       <= z_nxt;
      start_r   <= start_nxt;
      valid_r   <= valid_nxt;
      stale_r   <= stale_nxt;
      fault_r   <= fault_nxt;
    end
  end

  assign z_altitude_mm  = z_r;
  assign start_signal   = start_r;
  assign altitude_valid = valid_r;
  assign sensor_fault   = fault_r;

endmodule

// File: tb/tb_z_altitude_sampler.sv
// Directed bench for z_altitude_sampler with shortened timing; a second instance uses a 200 mm offset.
module tb_z_altitude_sampler;
  import z_altitude_sampler_pkg::*;

  localparam int P = 1000;

  logic us_clk = 1'b0;
  logic resetn;
  logic lidar_pwm;
  logic signed [RATE_BIT_WIDTH-1:0] z_mm, z2_mm;
  logic start, start2, valid, valid2, fault, fault2;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {int start; int len;} ev_t;
  ev_t ev_q[$];

  typedef struct {int start; int len; int tick; int ez; int ev; int ef; int ez2;} vec_t;
  vec_t vecs[5];

  z_altitude_sampler #(
    .SAMPLE_PERIOD_US(P), .TIMEOUT_US(2000), .MIN_PULSE_US(100),
    .OFFSET_MM(0), .MAX_MM(1500), .STALE_LIMIT(5)
  ) dut (
    .us_clk(us_clk), .resetn(resetn), .lidar_pwm(lidar_pwm),
    .z_altitude_mm(z_mm), .start_signal(start),
    .altitude_valid(valid), .sensor_fault(fault)
  );

  z_altitude_sampler #(
    .SAMPLE_PERIOD_US(P), .TIMEOUT_US(2000), .MIN_PULSE_US(100),
    .OFFSET_MM(200), .MAX_MM(1500), .STALE_LIMIT(5)
  ) dut_off (
    .us_clk(us_clk), .resetn(resetn), .lidar_pwm(lidar_pwm),
    .z_altitude_mm(z2_mm), .start_signal(start2),
    .altitude_valid(valid2), .sensor_fault(fault2)
  );

  always #5 us_clk = ~us_clk;

  // Cycle index since reset release; equals the DUT edge number.
  always @(posedge us_clk) begin
    if (!resetn) cyc <= 0;
    else cyc <= cyc + 1;
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  // Pin driver: high after posedge c for start <= c < start+len.
  initial begin
    bit hi;
    forever begin
      @(posedge us_clk);
      #1;
      hi = 1'b0;
      foreach (ev_q[i]) begin
        if (cyc >= ev_q[i].start && cyc < ev_q[i].start + ev_q[i].len) hi = 1'b1;
      end
      lidar_pwm = hi;
    end
  end

  // Tick spacing and output stability between ticks.
  initial begin
    int gap;
    int prev_z;
    gap = -1;
    prev_z = 0;
    forever begin
      @(negedge us_clk);
      if (!resetn) begin
        gap = -1;
      end else begin
        gap++;
        if (start) begin
          chk("start_gap", gap, P);
          gap = 0;
        end else begin
          chk("z_stable", int'(z_mm), prev_z);
        end
      end
      prev_z = int'(z_mm);
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check_tick(input string nm, input int t, input int ez, input int ev,
                            input int ef, input int ez2);
    while (cyc < t) @(negedge us_clk);
    chk({nm, "_start"}, int'(start), 1);
    chk({nm, "_z"}, int'(z_mm), ez);
    chk({nm, "_valid"}, int'(valid), ev);
    chk({nm, "_fault"}, int'(fault), ef);
    chk({nm, "_z_off"}, int'(z2_mm), ez2);
    chk({nm, "_valid_off"}, int'(valid2), ev);
    @(negedge us_clk);
    chk({nm, "_start_1cyc"}, int'(start), 0);
  endtask

  task automatic check_reset(input string nm);
    chk({nm, "_z"}, int'(z_mm), 0);
    chk({nm, "_start"}, int'(start), 0);
    chk({nm, "_valid"}, int'(valid), 0);
    chk({nm, "_fault"}, int'(fault), 0);
    chk({nm, "_z_off"}, int'(z2_mm), 0);
    chk({nm, "_start_off"}, int'(start2), 0);
    chk({nm, "_valid_off"}, int'(valid2), 0);
    chk({nm, "_fault_off"}, int'(fault2), 0);
  endtask

  initial begin
    resetn = 1'b0;
    lidar_pwm = 1'b0;
    // start, len, tick, z, valid, fault, z with 200 mm offset
    vecs[0] = '{10,   500, 1000, 500, 1, 0, 300};
    vecs[1] = '{1010, 150, 2000, 150, 1, 0, 0};
    vecs[2] = '{2010, 50,  3000, 150, 0, 0, 0};
    vecs[3] = '{3010, 0,   4000, 150, 0, 0, 0};
    vecs[4] = '{4010, 700, 5000, 700, 1, 0, 500};
    foreach (vecs[i]) if (vecs[i].len > 0) ev_q.push_back('{vecs[i].start, vecs[i].len});
    ev_q.push_back('{5010, 1800});
    ev_q.push_back('{7010, 2500});
    ev_q.push_back('{9610, 600});
    ev_q.push_back('{11010, 700});
    ev_q.push_back('{12196, 800});
    ev_q.push_back('{19010, 400});
    ev_q.push_back('{20010, 5000});

    repeat (3) @(posedge us_clk);
    @(negedge us_clk);
    check_reset("reset");
    @(posedge us_clk);
    #1 resetn = 1'b1;

    for (int i = 0; i < 5; i++) begin
      check_tick($sformatf("vec%0d", i), vecs[i].tick, vecs[i].ez, vecs[i].ev,
                 vecs[i].ef, vecs[i].ez2);
    end

    // Long pulse clamps to the maximum.
    check_tick("clamp_mid", 6000, 700, 0, 0, 500);
    check_tick("clamp_hi", 7000, 1500, 1, 0, 1500);
    // Pin held high past the timeout: no publish, later pulse measured cleanly.
    check_tick("abort_a", 8000, 1500, 0, 0, 1500);
    check_tick("abort_b", 9000, 1500, 0, 0, 1500);
    check_tick("abort_c", 10000, 1500, 0, 0, 1500);
    check_tick("after_abort", 11000, 600, 1, 0, 400);
    // Result computed on the tick edge is published one tick later.
    check_tick("prev_700", 12000, 700, 1, 0, 500);
    check_tick("coincide", 13000, 700, 0, 0, 500);
    check_tick("coincide_next", 14000, 800, 1, 0, 600);
    // Five stale ticks raise the fault; one good pulse clears it.
    for (int k = 1; k <= 5; k++) begin
      check_tick($sformatf("stale%0d", k), 14000 + k * P, 800, 0, (k == 5) ? 1 : 0, 600);
    end
    check_tick("fault_clear", 20000, 400, 1, 0, 200);

    // Reset in the middle of a pulse; the partial pulse must not be published.
    while (cyc < 20300) @(negedge us_clk);
    @(posedge us_clk);
    #2 resetn = 1'b0;
    ev_q.delete();
    ev_q.push_back('{0, 300});
    ev_q.push_back('{1010, 500});
    repeat (3) @(posedge us_clk);
    @(negedge us_clk);
    check_reset("midpulse_reset");
    @(posedge us_clk);
    #2 resetn = 1'b1;
    check_tick("post_reset_1", 1000, 0, 0, 0, 0);
    check_tick("post_reset_2", 2000, 500, 1, 0, 300);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
